// File: rtl/reg_file_wb.sv
// SimpleRISC architectural register file: 16 x 32-bit, two bypassed combinational
// read ports with ret/st operand select, one synchronous write port, debug read.
module reg_file_wb #(
  parameter int unsigned          DATA_W  = 32,
  parameter int unsigned          NREGS   = 16,
  parameter logic [DATA_W-1:0]    SP_INIT = 32'h0000_0FFC,
  localparam int unsigned         AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [AW-1:0]     rd,
  input  logic              isRet,
  input  logic              isSt,
  input  logic [AW-1:0]     wb_rd,
  input  logic              isWb,
  input  logic              isCall,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam logic [AW-1:0] SP_IDX = AW'(14);
  localparam logic [AW-1:0] RA_IDX = AW'(15);

  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     ra1, ra2, wa;
  logic              we;

  always_comb begin
    ra1 = isRet  ? RA_IDX : rs1;
    ra2 = isSt   ? rd     : rs2;
    wa  = isCall ? RA_IDX : wb_rd;
    we  = isWb | isCall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i[AW-1:0]] <= (i[AW-1:0] == SP_IDX) ? SP_INIT : '0;
      end
      wr_count <= '0;
    end else if (we) begin
      regs[wa] <= wb_data;
      wr_count <= wr_count + 16'd1;
    end
  end

  // Bypass is purely combinational, so it is visible even while reset is high.
  always_comb begin
    op1      = (we && (wa == ra1)) ? wb_data : regs[ra1];
    op2      = (we && (wa == ra2)) ? wb_data : regs[ra2];
    dbg_data = regs[dbg_addr];
  end

endmodule
